// File: rtl/bp_pkg.sv
// Shared constants and types for the branch predictor: table geometry,
// 2-bit counter encodings and the bit positions inside the branch flag pair.
package bp_pkg;
    localparam int BHT_ENTRIES = 8;
    localparam int IDX_W       = 3;
    localparam int TAG_W       = 27;
    localparam int FLAG_HIT    = 1;
    localparam int FLAG_TAKEN  = 0;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;
endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational 2-bit saturating counter next-state: taken counts up to ST,
// not-taken counts down to SNT.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) ctr_next = ctr_t'(ctr - 2'd1);
        end
    end
endmodule

// File: rtl/branch_predict_ctrl.sv
// 8-entry direct-mapped branch target buffer with 2-bit direction counters.
// Optional macro BHT_STATS_EN adds BranchCnt/MissCnt statistics outputs.
module branch_predict_ctrl
    import bp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PCF,
    input  logic [31:0]      PCE,
    input  logic             EnE,
    input  logic             BranchE,
    input  logic             BrTakenE,
    input  logic [31:0]      BrTargetE,
    input  logic [1:0]       BranchFlagsE,
    input  logic [IDX_W-1:0] BranchIndexE,
    output logic [31:0]      PredPC,
    output logic [1:0]       BranchFlags,
    output logic [IDX_W-1:0] BranchIndex,
    output logic             MispredictE,
    output logic [31:0]      RedirectPC
`ifdef BHT_STATS_EN
    ,
    output logic [31:0]      BranchCnt,
    output logic [31:0]      MissCnt
`endif
);
    logic             valid_q  [BHT_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BHT_ENTRIES];
    logic [31:0]      target_q [BHT_ENTRIES];
    ctr_t             ctr_q    [BHT_ENTRIES];

    // Fetch-side lookup always reads pre-edge state, so a same-cycle update
    // at the same index is not forwarded.
    logic [IDX_W-1:0] f_idx;
    logic             f_hit;
    logic             f_taken;

    assign f_idx       = PCF[4:2];
    assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == PCF[31:5]);
    assign f_taken     = f_hit && (ctr_q[f_idx] inside {WT, ST});
    assign PredPC      = f_taken ? target_q[f_idx] : PCF + 32'd4;
    assign BranchFlags = {f_hit, f_taken};
    assign BranchIndex = f_idx;

    // The fetch-time hit flag may be stale by EX; hit is recomputed here.
    logic unused_hit_flag;
    assign unused_hit_flag = BranchFlagsE[FLAG_HIT];

    logic [IDX_W-1:0] e_idx;
    logic             br_upd;
    logic             alias_inv;
    logic             e_hit;
    logic             pred_taken;
    logic             tgt_wrong;
    ctr_t             ctr_next;

    assign e_idx      = BranchIndexE;
    assign br_upd     = EnE && BranchE;
    assign alias_inv  = EnE && !BranchE && BranchFlagsE[FLAG_TAKEN];
    assign e_hit      = valid_q[e_idx] && (tag_q[e_idx] == PCE[31:5]);
    assign pred_taken = BranchFlagsE[FLAG_TAKEN];
    assign tgt_wrong  = BrTakenE && pred_taken && (target_q[e_idx] != BrTargetE);

    assign MispredictE = (br_upd && ((pred_taken != BrTakenE) || tgt_wrong)) || alias_inv;
    assign RedirectPC  = (!alias_inv && BrTakenE) ? BrTargetE : PCE + 32'd4;

    bp_sat_ctr u_sat_ctr (
        .ctr      (ctr_q[e_idx]),
        .taken    (BrTakenE),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
        end else if (br_upd) begin
            if (e_hit) begin
                ctr_q[e_idx] <= ctr_next;
                if (BrTakenE) target_q[e_idx] <= BrTargetE;
            end else if (BrTakenE) begin
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= PCE[31:5];
                target_q[e_idx] <= BrTargetE;
                ctr_q[e_idx]    <= WT;
            end
        end else if (alias_inv) begin
            // A non-branch predicted taken means the entry aliases: drop it.
            valid_q[e_idx] <= 1'b0;
        end
    end

`ifdef BHT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            BranchCnt <= 32'd0;
            MissCnt   <= 32'd0;
        end else begin
            if (br_upd)      BranchCnt <= BranchCnt + 32'd1;
            if (MispredictE) MissCnt   <= MissCnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl; define BHT_STATS_EN to also
// exercise the statistics counters.
module tb_branch_predict_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, BrTargetE;
    logic        EnE, BranchE, BrTakenE;
    logic [1:0]  BranchFlagsE;
    logic [2:0]  BranchIndexE;
    logic [31:0] PredPC, RedirectPC;
    logic [1:0]  BranchFlags;
    logic [2:0]  BranchIndex;
    logic        MispredictE;
`ifdef BHT_STATS_EN
    logic [31:0] BranchCnt, MissCnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pcf, pce;
        logic        en, br, tk;
        logic [31:0] tgt;
        logic [1:0]  fe;
        logic [2:0]  ie;
        logic [1:0]  xf;
        logic [31:0] xp;
        logic [2:0]  xi;
        logic        xm;
        logic [31:0] xr;
        logic        cr;
    } step_t;

    step_t sb[$];

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .PCF          (PCF),
        .PCE          (PCE),
        .EnE          (EnE),
        .BranchE      (BranchE),
        .BrTakenE     (BrTakenE),
        .BrTargetE    (BrTargetE),
        .BranchFlagsE (BranchFlagsE),
        .BranchIndexE (BranchIndexE),
        .PredPC       (PredPC),
        .BranchFlags  (BranchFlags),
        .BranchIndex  (BranchIndex),
        .MispredictE  (MispredictE),
        .RedirectPC   (RedirectPC)
`ifdef BHT_STATS_EN
        ,
        .BranchCnt    (BranchCnt),
        .MissCnt      (MissCnt)
`endif
    );

    // Drive one cycle of stimulus just after the edge and queue its expectation.
    task automatic apply_step(input step_t s);
        @(posedge clk);
        #1;
        PCF = s.pcf; PCE = s.pce; EnE = s.en; BranchE = s.br; BrTakenE = s.tk;
        BrTargetE = s.tgt; BranchFlagsE = s.fe; BranchIndexE = s.ie;
        sb.push_back(s);
    endtask

    function automatic step_t idle(input logic [31:0] pcf, input logic [1:0] xf,
                                   input logic [31:0] xp, input logic [2:0] xi);
        return '{pcf, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 3'd0, xf, xp, xi, 1'b0, 32'h0, 1'b0};
    endfunction

    task automatic test_reset();
        step_t e;
        rst = 1'b1;
        @(posedge clk);
        #1;
        PCF = 32'h100; PCE = 32'h100; EnE = 1'b1; BranchE = 1'b1; BrTakenE = 1'b1;
        BrTargetE = 32'h200; BranchFlagsE = 2'b00; BranchIndexE = 3'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        EnE = 1'b0; BranchE = 1'b0; BrTakenE = 1'b0;
        sb.push_back(idle(32'h100, 2'b00, 32'h104, 3'd0));
        @(negedge clk);
        e = sb.pop_front();
        total += 2;
        if ({BranchFlags, PredPC, BranchIndex} !== {e.xf, e.xp, e.xi}) begin
            bad++;
            $display("FAIL reset lookup: got flags=%b pred=%h idx=%0d, want flags=%b pred=%h idx=%0d",
                     BranchFlags, PredPC, BranchIndex, e.xf, e.xp, e.xi);
        end
        if (MispredictE !== 1'b0) begin
            bad++;
            $display("FAIL reset mispredict: got %b, want 0", MispredictE);
        end
    endtask

    task automatic run_steps(input string nm, input step_t st[$]);
        step_t e;
        foreach (st[i]) begin
            apply_step(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            total += 2;
            if ({BranchFlags, PredPC, BranchIndex} !== {e.xf, e.xp, e.xi}) begin
                bad++;
                $display("FAIL %s[%0d] lookup: got flags=%b pred=%h idx=%0d, want flags=%b pred=%h idx=%0d",
                         nm, i, BranchFlags, PredPC, BranchIndex, e.xf, e.xp, e.xi);
            end
            if (MispredictE !== e.xm || (e.cr && RedirectPC !== e.xr)) begin
                bad++;
                $display("FAIL %s[%0d] resolve: got mis=%b redir=%h, want mis=%b redir=%h",
                         nm, i, MispredictE, RedirectPC, e.xm, e.xr);
            end
        end
    endtask

    task automatic test_allocate();
        step_t st[$];
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b00, 3'd0, 2'b00, 32'h104, 3'd0, 1'b1, 32'h200, 1'b1});
        st.push_back(idle(32'h100, 2'b11, 32'h200, 3'd0));
        run_steps("allocate", st);
    endtask

    task automatic test_saturate();
        step_t st[$];
        step_t tk = '{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b11, 3'd0, 2'b11, 32'h200, 3'd0, 1'b0, 32'h200, 1'b1};
        step_t nt = '{32'h100, 32'h100, 1'b1, 1'b1, 1'b0, 32'h200, 2'b11, 3'd0, 2'b11, 32'h200, 3'd0, 1'b1, 32'h104, 1'b1};
        st.push_back(tk);
        st.push_back(tk);
        st.push_back(tk);
        st.push_back(nt);
        st.push_back(idle(32'h100, 2'b11, 32'h200, 3'd0));
        st.push_back(nt);
        st.push_back(idle(32'h100, 2'b10, 32'h104, 3'd0));
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h300, 2'b10, 3'd0, 2'b10, 32'h104, 3'd0, 1'b1, 32'h300, 1'b1});
        st.push_back(idle(32'h100, 2'b11, 32'h300, 3'd0));
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b11, 3'd0, 2'b11, 32'h300, 3'd0, 1'b1, 32'h200, 1'b1});
        st.push_back(idle(32'h100, 2'b11, 32'h200, 3'd0));
        run_steps("saturate", st);
    endtask

    task automatic test_alias();
        step_t st[$];
        st.push_back('{32'h100, 32'h120, 1'b1, 1'b0, 1'b0, 32'h0, 2'b11, 3'd0, 2'b11, 32'h200, 3'd0, 1'b1, 32'h124, 1'b1});
        st.push_back(idle(32'h100, 2'b00, 32'h104, 3'd0));
        run_steps("alias", st);
    endtask

    task automatic test_no_update();
        step_t st[$];
        st.push_back('{32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 2'b00, 3'd0, 2'b00, 32'h104, 3'd0, 1'b0, 32'h0, 1'b0});
        st.push_back(idle(32'h100, 2'b00, 32'h104, 3'd0));
        st.push_back('{32'h140, 32'h140, 1'b1, 1'b1, 1'b0, 32'h180, 2'b00, 3'd0, 2'b00, 32'h144, 3'd0, 1'b0, 32'h0, 1'b0});
        st.push_back('{32'h140, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0, 2'b11, 3'd0, 2'b00, 32'h144, 3'd0, 1'b0, 32'h0, 1'b0});
        st.push_back(idle(32'h140, 2'b00, 32'h144, 3'd0));
        run_steps("no_update", st);
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b00, 3'd0, 2'b00, 32'h104, 3'd0, 1'b1, 32'h200, 1'b1});
        st.push_back('{32'h100, 32'h120, 1'b1, 1'b1, 1'b1, 32'h500, 2'b00, 3'd0, 2'b11, 32'h200, 3'd0, 1'b1, 32'h500, 1'b1});
        st.push_back(idle(32'h100, 2'b00, 32'h104, 3'd0));
        st.push_back(idle(32'h120, 2'b11, 32'h500, 3'd0));
        run_steps("back_to_back", st);
    endtask

    task automatic test_wrap();
        step_t st[$];
        st.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'h8, 2'b00, 3'd7, 2'b00, 32'h0, 3'd7, 1'b1, 32'h8, 1'b1});
        st.push_back(idle(32'hFFFF_FFFC, 2'b11, 32'h8, 3'd7));
        st.push_back(idle(32'h1C, 2'b00, 32'h20, 3'd7));
        st.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h8, 2'b11, 3'd7, 2'b11, 32'h8, 3'd7, 1'b1, 32'h0, 1'b1});
        st.push_back(idle(32'hFFFF_FFFC, 2'b10, 32'h0, 3'd7));
        run_steps("wrap", st);
    endtask

`ifdef BHT_STATS_EN
    task automatic test_stats();
        step_t st[$];
        @(posedge clk);
        #1;
        rst = 1'b1; EnE = 1'b0; BranchE = 1'b0;
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b00, 3'd0, 2'b00, 32'h104, 3'd0, 1'b1, 32'h200, 1'b1});
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b11, 3'd0, 2'b11, 32'h200, 3'd0, 1'b0, 32'h200, 1'b1});
        st.push_back('{32'h100, 32'h100, 1'b1, 1'b1, 1'b1, 32'h200, 2'b11, 3'd0, 2'b11, 32'h200, 3'd0, 1'b0, 32'h200, 1'b1});
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_steps("stats", st);
        apply_step(idle(32'h100, 2'b11, 32'h200, 3'd0));
        @(negedge clk);
        void'(sb.pop_front());
        total++;
        if (BranchCnt !== 32'd3 || MissCnt !== 32'd1) begin
            bad++;
            $display("FAIL stats count: got branch=%0d miss=%0d, want branch=3 miss=1", BranchCnt, MissCnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (BranchCnt !== 32'd0 || MissCnt !== 32'd0) begin
            bad++;
            $display("FAIL stats reset: got branch=%0d miss=%0d, want 0 and 0", BranchCnt, MissCnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; PCF = 32'h0; PCE = 32'h0; EnE = 1'b0; BranchE = 1'b0; BrTakenE = 1'b0;
        BrTargetE = 32'h0; BranchFlagsE = 2'b00; BranchIndexE = 3'd0;
        test_reset();
        test_allocate();
        test_saturate();
        test_alias();
        test_no_update();
        test_back_to_back();
        test_wrap();
`ifdef BHT_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
